// File: rtl/demux2_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package  : demux2_pkg                                            |
// | Purpose  : shared defaults and port-index constants for the      |
// |            registered 1-to-2 stream demultiplexer                |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package demux2_pkg;
  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Select value that steers a beat to each output port
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage
`default_nettype wire

// File: rtl/demux2_stream_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface: demux2_stream_if                                      |
// | Purpose  : input stream, two output streams and status of the    |
// |            1-to-2 stream demultiplexer                           |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface demux2_stream_if #(
  parameter int WIDTH     = demux2_pkg::DEFAULT_WIDTH,
  parameter int CNT_WIDTH = demux2_pkg::DEFAULT_CNT_WIDTH
);
  logic [WIDTH-1:0]     D;
  logic                 SL;
  logic                 VLD_IN;
  logic                 RDY_IN;
  logic [WIDTH-1:0]     Z0;
  logic                 VLD0;
  logic                 RDY0;
  logic [WIDTH-1:0]     Z1;
  logic                 VLD1;
  logic                 RDY1;
  logic [CNT_WIDTH-1:0] CNT0;
  logic [CNT_WIDTH-1:0] CNT1;
  logic                 SL_ERR;

  // Producer / consumer side: drives the input beat and the consumer readies
  modport master (
    output D, SL, VLD_IN, RDY0, RDY1,
    input  RDY_IN, Z0, VLD0, Z1, VLD1, CNT0, CNT1, SL_ERR
  );

  // Demultiplexer side
  modport slave (
    input  D, SL, VLD_IN, RDY0, RDY1,
    output RDY_IN, Z0, VLD0, Z1, VLD1, CNT0, CNT1, SL_ERR
  );
endinterface
`default_nettype wire

// File: rtl/demux2_stream_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : demux_slot                                            |
// | Purpose  : one-entry output holding register with valid/ready,   |
// |            free flag and accepted-beat counter                   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module demux_slot #(
  parameter int WIDTH     = demux2_pkg::DEFAULT_WIDTH,
  parameter int CNT_WIDTH = demux2_pkg::DEFAULT_CNT_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 load,
  input  wire logic [WIDTH-1:0]     din,
  input  wire logic                 rdy,
  output logic      [WIDTH-1:0]     dout,
  output logic                      vld,
  output logic      [CNT_WIDTH-1:0] cnt,
  output logic                      free
);
  // Slot can take a beat when empty or when it is being drained this cycle
  assign free = !vld || rdy;

  // Holding register: load wins over drain; data changes only on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      vld  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      dout <= din;
      vld  <= 1'b1;
      cnt  <= cnt + 1'b1;
    end else if (vld && rdy) begin
      vld  <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: rtl/demux2_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : demux2_stream                                         |
// | Purpose  : registered 1-to-2 stream demultiplexer; steers each   |
// |            input beat to port 0 or 1 by SL, flags unknown SL     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module demux2_stream #(
  parameter int WIDTH     = demux2_pkg::DEFAULT_WIDTH,
  parameter int CNT_WIDTH = demux2_pkg::DEFAULT_CNT_WIDTH
) (
  input wire logic         CK,
  input wire logic         RST,
  demux2_stream_if.slave   bus
);
  import demux2_pkg::*;

  logic sl_unknown;
  logic free0;
  logic free1;
  logic accept;
  logic load0;
  logic load1;
  logic sl_err;

  // Case inequality catches X/Z on SL in four-state simulation; a real
  // netlist only ever sees 0/1 here, so this term is constant false there
  assign sl_unknown = (bus.SL !== PORT0) && (bus.SL !== PORT1);

  // Ready depends only on the selected slot, never on VLD_IN
  assign bus.RDY_IN = !RST && !sl_unknown &&
                      ((bus.SL == PORT1) ? free1 : free0);

  assign accept = bus.VLD_IN && bus.RDY_IN;
  assign load0  = accept && (bus.SL == PORT0);
  assign load1  = accept && (bus.SL == PORT1);

  demux_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot0 (
    .clk  (CK),
    .rst  (RST),
    .load (load0),
    .din  (bus.D),
    .rdy  (bus.RDY0),
    .dout (bus.Z0),
    .vld  (bus.VLD0),
    .cnt  (bus.CNT0),
    .free (free0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot1 (
    .clk  (CK),
    .rst  (RST),
    .load (load1),
    .din  (bus.D),
    .rdy  (bus.RDY1),
    .dout (bus.Z1),
    .vld  (bus.VLD1),
    .cnt  (bus.CNT1),
    .free (free1)
  );

  // Sticky flag: a valid beat presented with an unknown select
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sl_err <= 1'b0;
    end else if (bus.VLD_IN && sl_unknown) begin
      sl_err <= 1'b1;
    end
  end

  assign bus.SL_ERR = sl_err;
endmodule
`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_demux2_stream                                      |
// | Purpose  : directed self-checking bench for demux2_stream        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_demux2_stream;
  logic CK;
  logic RST;
  int   total;
  int   bad;
  logic probe;
  logic four_state;
  logic exp_err;

  demux2_stream_if #(.WIDTH(8), .CNT_WIDTH(16)) bus ();
  demux2_stream_if #(.WIDTH(8), .CNT_WIDTH(4))  bus4 ();

  demux2_stream #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus.slave)
  );

  demux2_stream #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .CK  (CK),
    .RST (RST),
    .bus (bus4.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs have settled
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Let combinational RDY_IN settle after an input change
  task automatic settle();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    probe = 1'bx;
    four_state = $isunknown(probe);
    exp_err = four_state;

    RST = 1'b1;
    bus.D = '0;  bus.SL = 1'b0; bus.VLD_IN = 1'b0; bus.RDY0 = 1'b0; bus.RDY1 = 1'b0;
    bus4.D = '0; bus4.SL = 1'b0; bus4.VLD_IN = 1'b0; bus4.RDY0 = 1'b0; bus4.RDY1 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_vld0", bus.VLD0, 0);
    chk("rst_vld1", bus.VLD1, 0);
    chk("rst_z0", bus.Z0, 0);
    chk("rst_z1", bus.Z1, 0);
    chk("rst_cnt0", bus.CNT0, 0);
    chk("rst_cnt1", bus.CNT1, 0);
    chk("rst_slerr", bus.SL_ERR, 0);
    chk("rst_rdyin", bus.RDY_IN, 0);

    // Steering: 0x11 to port 0, then 0x22 to port 1
    RST = 1'b0;
    bus.RDY0 = 1'b1; bus.RDY1 = 1'b1;
    bus.D = 8'h11; bus.SL = 1'b0; bus.VLD_IN = 1'b1;
    settle();
    chk("steer_rdy_a", bus.RDY_IN, 1);
    tick();
    chk("steer_z0", bus.Z0, 8'h11);
    chk("steer_vld0", bus.VLD0, 1);
    chk("steer_cnt0", bus.CNT0, 1);
    bus.D = 8'h22; bus.SL = 1'b1;
    settle();
    chk("steer_rdy_b", bus.RDY_IN, 1);
    tick();
    chk("steer_z1", bus.Z1, 8'h22);
    chk("steer_vld1", bus.VLD1, 1);
    chk("steer_cnt1", bus.CNT1, 1);
    chk("drain_vld0", bus.VLD0, 0);
    chk("drain_z0_hold", bus.Z0, 8'h11);

    // Backpressure isolation: fill port 0 and stall it
    bus.RDY0 = 1'b0;
    bus.D = 8'h44; bus.SL = 1'b0;
    tick();
    chk("bp_z0_load", bus.Z0, 8'h44);
    chk("bp_cnt0", bus.CNT0, 2);
    chk("bp_vld1_drained", bus.VLD1, 0);
    bus.D = 8'h55; bus.SL = 1'b0;
    settle();
    chk("bp_rdy_stall", bus.RDY_IN, 0);
    tick();
    chk("bp_z0_hold", bus.Z0, 8'h44);
    chk("bp_cnt0_hold", bus.CNT0, 2);
    bus.D = 8'h33; bus.SL = 1'b1;
    settle();
    chk("bp_rdy_other", bus.RDY_IN, 1);
    tick();
    chk("bp_z1", bus.Z1, 8'h33);
    chk("bp_cnt1", bus.CNT1, 2);
    chk("bp_vld0_kept", bus.VLD0, 1);
    chk("bp_z0_kept", bus.Z0, 8'h44);

    // Throughput: ten back-to-back beats to port 1
    for (int i = 0; i < 10; i++) begin
      bus.D = 8'(i); bus.SL = 1'b1;
      settle();
      chk("tp_rdy", bus.RDY_IN, 1);
      tick();
      chk("tp_z1", bus.Z1, i);
      chk("tp_vld1", bus.VLD1, 1);
    end
    chk("tp_cnt1", bus.CNT1, 12);

    // Unknown select with both ports full and stalled
    bus.RDY1 = 1'b0;
    bus.SL = probe; bus.D = 8'hEE; bus.VLD_IN = 1'b1;
    settle();
    chk("x_rdy", bus.RDY_IN, 0);
    tick();
    chk("x_vld0", bus.VLD0, 1);
    chk("x_vld1", bus.VLD1, 1);
    chk("x_z0", bus.Z0, 8'h44);
    chk("x_z1", bus.Z1, 8'h09);
    chk("x_cnt0", bus.CNT0, 2);
    chk("x_cnt1", bus.CNT1, 12);
    chk("x_slerr", bus.SL_ERR, 32'(exp_err));

    // Valid traffic resumes; error flag stays
    bus.RDY0 = 1'b1;
    bus.SL = 1'b0; bus.D = 8'h66;
    settle();
    chk("resume_rdy", bus.RDY_IN, 1);
    tick();
    chk("resume_z0", bus.Z0, 8'h66);
    chk("resume_cnt0", bus.CNT0, 3);
    chk("resume_slerr", bus.SL_ERR, 32'(exp_err));
    bus.D = 8'h77;
    tick();
    bus.D = 8'h88;
    tick();
    chk("pre_rst_cnt0", bus.CNT0, 5);
    chk("pre_rst_vld0", bus.VLD0, 1);
    chk("pre_rst_z0", bus.Z0, 8'h88);
    chk("pre_rst_slerr", bus.SL_ERR, 32'(exp_err));

    // Asynchronous reset mid-stream, checked before any clock edge
    bus.VLD_IN = 1'b0;
    RST = 1'b1;
    settle();
    chk("arst_vld0", bus.VLD0, 0);
    chk("arst_vld1", bus.VLD1, 0);
    chk("arst_cnt0", bus.CNT0, 0);
    chk("arst_cnt1", bus.CNT1, 0);
    chk("arst_z0", bus.Z0, 0);
    chk("arst_slerr", bus.SL_ERR, 0);
    chk("arst_rdyin", bus.RDY_IN, 0);
    tick();

    // First accept on the first edge after release
    RST = 1'b0;
    bus.D = 8'hA5; bus.SL = 1'b0; bus.VLD_IN = 1'b1; bus.RDY0 = 1'b1;
    settle();
    chk("post_rst_rdy", bus.RDY_IN, 1);
    tick();
    chk("post_rst_z0", bus.Z0, 8'hA5);
    chk("post_rst_vld0", bus.VLD0, 1);
    chk("post_rst_cnt0", bus.CNT0, 1);
    bus.VLD_IN = 1'b0;

    // Counter wrap on the 4-bit instance: 17 beats to port 0
    bus4.RDY0 = 1'b1; bus4.SL = 1'b0; bus4.VLD_IN = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus4.D = 8'(i);
      tick();
      if (i == 15) chk("wrap_cnt0_16", bus4.CNT0, 0);
    end
    bus4.VLD_IN = 1'b0;
    chk("wrap_cnt0_17", bus4.CNT0, 1);
    chk("wrap_z0", bus4.Z0, 8'h10);
    chk("wrap_cnt1", bus4.CNT1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
